// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack port bundle for the MEM stage.
// master = pipeline stage side, slave = memory side.
interface mem_access_stage_if #(
    parameter int WIDTH = 32
);
    logic             dmem_req_out;
    logic             dmem_we_out;
    logic [WIDTH-1:0] dmem_addr_out;
    logic [3:0]       dmem_be_out;
    logic [WIDTH-1:0] dmem_wdata_out;
    logic             dmem_ack_in;
    logic [WIDTH-1:0] dmem_rdata_in;

    modport master (
        output dmem_req_out, dmem_we_out, dmem_addr_out, dmem_be_out, dmem_wdata_out,
        input  dmem_ack_in, dmem_rdata_in
    );

    modport slave (
        input  dmem_req_out, dmem_we_out, dmem_addr_out, dmem_be_out, dmem_wdata_out,
        output dmem_ack_in, dmem_rdata_in
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: store lane steering, load extension, req/ack stall, one write-back beat.
// Define MEM_TIMEOUT_EN to add the ack watchdog and the bus_err_out port.
module mem_access_stage #(
    parameter int WIDTH   = 32,
    parameter int INDEX   = 5,
    parameter int TIMEOUT = 255
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               flush_in,
    input  logic               valid_in,
    input  logic               mem_read_in,
    input  logic               mem_write_in,
    input  logic               reg_write_in,
    input  logic [2:0]         funct3_in,
    input  logic [WIDTH-1:0]   alu_res_in,
    input  logic [WIDTH-1:0]   drs2_in,
    input  logic [INDEX-1:0]   rd_in,
    mem_access_stage_if.master dmem,
    output logic               stall_out,
    output logic               valid_out,
    output logic               reg_write_out,
    output logic [INDEX-1:0]   rd_out,
    output logic [WIDTH-1:0]   wb_data_out,
    output logic               misalign_out
`ifdef MEM_TIMEOUT_EN
    ,
    output logic               bus_err_out
`endif
);

    if (WIDTH != 32 || TIMEOUT < 1) begin : g_param_check
        $error("mem_access_stage: WIDTH must be 32 and TIMEOUT must be >= 1");
    end

    // state  | meaning
    // IDLE   | accepting instructions; non-memory and misaligned ops retire in one cycle
    // ACCESS | request outstanding on dmem, pipeline stalled until ack
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   addr_q, addr_d;
    logic [3:0]         be_q, be_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic               we_q, we_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [INDEX-1:0]   rd_q, rd_d;
    logic               reg_write_q, reg_write_d;
    logic               valid_out_q, valid_out_d;
    logic               reg_write_out_q, reg_write_out_d;
    logic [INDEX-1:0]   rd_out_q, rd_out_d;
    logic [WIDTH-1:0]   wb_data_q, wb_data_d;
    logic               misalign_q, misalign_d;
`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bus_err_q, bus_err_d;
`endif

    logic               is_mem;
    logic               misaligned;
    logic [1:0]         lane;
    logic [3:0]         be_new;
    logic [WIDTH-1:0]   wdata_new;
    logic [WIDTH-1:0]   load_shift;
    logic [WIDTH-1:0]   load_data;

    always_comb begin
        is_mem     = mem_read_in | mem_write_in;
        lane       = alu_res_in[1:0];
        misaligned = 1'b0;
        be_new     = 4'b1111;
        wdata_new  = drs2_in;
        case (funct3_in[1:0])
            2'b00: begin
                be_new    = 4'b0001 << lane;
                wdata_new = {4{drs2_in[7:0]}};
            end
            2'b01: begin
                misaligned = lane[0];
                be_new     = 4'b0011 << {lane[1], 1'b0};
                wdata_new  = {2{drs2_in[15:0]}};
            end
            default: begin
                misaligned = |lane;
            end
        endcase

        // Extraction uses the latched address/size, since the inputs may be stale by ack time.
        load_shift = dmem.dmem_rdata_in >> {addr_q[1:0], 3'b000};
        case (funct3_q[1:0])
            2'b00:   load_data = {{24{~funct3_q[2] & load_shift[7]}}, load_shift[7:0]};
            2'b01:   load_data = {{16{~funct3_q[2] & load_shift[15]}}, load_shift[15:0]};
            default: load_data = load_shift;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        be_d            = be_q;
        wdata_d         = wdata_q;
        we_d            = we_q;
        funct3_d        = funct3_q;
        rd_d            = rd_q;
        reg_write_d     = reg_write_q;
        valid_out_d     = 1'b0;
        reg_write_out_d = 1'b0;
        rd_out_d        = rd_out_q;
        wb_data_d       = wb_data_q;
        misalign_d      = 1'b0;
        stall_out       = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d           = cnt_q;
        bus_err_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (valid_in && !flush_in) begin
                    if (!is_mem) begin
                        valid_out_d     = 1'b1;
                        reg_write_out_d = reg_write_in;
                        rd_out_d        = rd_in;
                        wb_data_d       = alu_res_in;
                    end else if (misaligned) begin
                        valid_out_d = 1'b1;
                        misalign_d  = 1'b1;
                        rd_out_d    = rd_in;
                        wb_data_d   = alu_res_in;
                    end else begin
                        state_d     = ACCESS;
                        stall_out   = 1'b1;
                        addr_d      = alu_res_in;
                        be_d        = be_new;
                        wdata_d     = wdata_new;
                        we_d        = mem_write_in;
                        funct3_d    = funct3_in;
                        rd_d        = rd_in;
                        reg_write_d = reg_write_in;
`ifdef MEM_TIMEOUT_EN
                        cnt_d       = CNT_W'(TIMEOUT - 1);
`endif
                    end
                end
            end
            ACCESS: begin
                if (dmem.dmem_ack_in) begin
                    state_d         = IDLE;
                    valid_out_d     = 1'b1;
                    rd_out_d        = rd_q;
                    reg_write_out_d = reg_write_q & ~we_q;
                    if (!we_q) begin
                        wb_data_d = load_data;
                    end
`ifdef MEM_TIMEOUT_EN
                end else if (cnt_q == '0) begin
                    state_d     = IDLE;
                    valid_out_d = 1'b1;
                    rd_out_d    = rd_q;
                    bus_err_d   = 1'b1;
                end else begin
                    cnt_d     = cnt_q - 1'b1;
                    stall_out = 1'b1;
`else
                end else begin
                    stall_out = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            be_q            <= '0;
            wdata_q         <= '0;
            we_q            <= 1'b0;
            funct3_q        <= '0;
            rd_q            <= '0;
            reg_write_q     <= 1'b0;
            valid_out_q     <= 1'b0;
            reg_write_out_q <= 1'b0;
            rd_out_q        <= '0;
            wb_data_q       <= '0;
            misalign_q      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q           <= '0;
            bus_err_q       <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            be_q            <= be_d;
            wdata_q         <= wdata_d;
            we_q            <= we_d;
            funct3_q        <= funct3_d;
            rd_q            <= rd_d;
            reg_write_q     <= reg_write_d;
            valid_out_q     <= valid_out_d;
            reg_write_out_q <= reg_write_out_d;
            rd_out_q        <= rd_out_d;
            wb_data_q       <= wb_data_d;
            misalign_q      <= misalign_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q           <= cnt_d;
            bus_err_q       <= bus_err_d;
`endif
        end
    end

    assign dmem.dmem_req_out   = (state_q == ACCESS);
    assign dmem.dmem_we_out    = we_q;
    assign dmem.dmem_addr_out  = {addr_q[WIDTH-1:2], 2'b00};
    assign dmem.dmem_be_out    = be_q;
    assign dmem.dmem_wdata_out = wdata_q;

    assign valid_out     = valid_out_q;
    assign reg_write_out = reg_write_out_q;
    assign rd_out        = rd_out_q;
    assign wb_data_out   = wb_data_q;
    assign misalign_out  = misalign_q;
`ifdef MEM_TIMEOUT_EN
    assign bus_err_out   = bus_err_q;
`endif

endmodule
